// File: rtl/cgra_pkg.sv
// ============================================================================
// Module      : cgra_pkg
// Description : Shared CGRA processing-element opcodes and load/store FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cgra_pkg;

    localparam logic [4:0] OPC_LOAD  = 5'b10010;
    localparam logic [4:0] OPC_STORE = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    function automatic logic is_mem_op(input logic [4:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_pe.sv
// ============================================================================
// Module      : lsu_pe
// Description : PE load/store unit issuing one req/gnt/rvalid memory transaction
//               per LOAD/STORE command and returning load data to the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_pe
    import cgra_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Exec_En_Global,
    input  logic              LSU_En,
    input  logic [4:0]        Opcode,
    input  logic [DWIDTH-1:0] Addr_In,
    input  logic [DWIDTH-1:0] Store_Data_In,
    output logic              data_req_o,
    output logic [AWIDTH-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DWIDTH-1:0] data_wdata_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [DWIDTH-1:0] data_rdata_i,
    output logic [31:0]       load_data_o,
    output logic              data_req_valid_o,
    output logic              busy_o,
    output logic              err_o
);

    // A zero TIMEOUT still needs a 1-bit counter to keep the declarations legal.
    localparam int                  c_WDOG_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                  c_WDOG_EN   = (TIMEOUT > 0);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t          r_state;
    lsu_state_t          w_state_nxt;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wdata;
    logic                r_we;
    logic [31:0]         r_load_data;
    logic                r_err;
    logic [c_WDOG_W-1:0] r_wdog;

    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;
    logic                w_wdog_run;
    logic                w_unused;

    // Byte offset is dropped: the memory port is word-addressed.
    assign w_unused = ^Addr_In[1:0];

    always_comb begin
        w_state_nxt      = r_state;
        data_req_o       = 1'b0;
        data_be_o        = 4'b0000;
        data_req_valid_o = 1'b0;
        busy_o           = 1'b1;
        w_accept         = 1'b0;
        w_capture        = 1'b0;
        w_timeout        = 1'b0;
        w_wdog_run       = 1'b0;

        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (Exec_En_Global && LSU_En && is_mem_op(Opcode)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // The request stays up until granted, whatever the PE does meanwhile.
                data_req_o = 1'b1;
                data_be_o  = 4'b1111;
                if (data_gnt_i) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    if (r_we) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = RESP;
                    end
                end else if (c_WDOG_EN && (r_wdog == c_WDOG_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wdog_run = 1'b1;
                end
            end
            RESP: begin
                data_req_valid_o = 1'b1;
                w_state_nxt      = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_load_data <= '0;
            r_err       <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= {Addr_In[AWIDTH-1:2], 2'b00};
                r_wdata <= Store_Data_In;
                r_we    <= (Opcode == OPC_STORE);
            end
            if (w_capture) begin
                r_load_data <= data_rdata_i[31:0];
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // Counter only advances across consecutive silent WAIT cycles.
            if (w_wdog_run) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign data_addr_o  = r_addr;
    assign data_we_o    = r_we;
    assign data_wdata_o = r_wdata;
    assign load_data_o  = r_load_data;
    assign err_o        = r_err;

endmodule

`default_nettype wire
